bit_ram_op_sched: RTL and testbench

//  Shares one bit-RAM instance between two requesters: the CPU bit-logic unit (req 0) and the IO scan engine (req 1).

---
 rtl/bit_ram_op_sched_pkg.sv | 34 +++
 rtl/bit_ram_op_sched_if.sv | 23 ++
 rtl/bit_ram_op_sched_rr_arb.sv | 33 +++
 rtl/bit_ram_op_sched.sv | 114 +++++++++++
 tb/tb_bit_ram_op_sched.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bit_ram_op_sched_pkg.sv
// Shared opcodes, FSM encoding and the bit-combine function for the bit-RAM operation scheduler.
package bit_ram_op_pkg;

  localparam logic [2:0] OP_READ = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SET  = 3'd6;
  localparam logic [2:0] OP_CLR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  function automatic logic bit_op_eval(input logic [2:0] op, input logic a, input logic b);
    logic f;
    case (op)
      OP_READ: f = a;
      OP_MOV:  f = a;
      OP_NOT:  f = ~a;
      OP_AND:  f = a & b;
      OP_OR:   f = a | b;
      OP_XOR:  f = a ^ b;
      OP_SET:  f = 1'b1;
      default: f = 1'b0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bit_ram_op_sched_if.sv
// Requester-side bus of the scheduler: two packed request channels plus the shared response.
interface bit_ram_op_sched_if #(
  parameter int AWIDTH = 2
);
  logic [1:0]          REQ_VALID;
  logic [1:0]          REQ_READY;
  logic [5:0]          REQ_OP;
  logic [2*AWIDTH-1:0] REQ_ADDR_A;
  logic [2*AWIDTH-1:0] REQ_ADDR_B;
  logic [2*AWIDTH-1:0] REQ_ADDR_D;
  logic [1:0]          RSP_VALID;
  logic                RSP_DATA;

  modport master (
    output REQ_VALID, REQ_OP, REQ_ADDR_A, REQ_ADDR_B, REQ_ADDR_D,
    input  REQ_READY, RSP_VALID, RSP_DATA
  );

  modport slave (
    input  REQ_VALID, REQ_OP, REQ_ADDR_A, REQ_ADDR_B, REQ_ADDR_D,
    output REQ_READY, RSP_VALID, RSP_DATA
  );
endinterface

// File: rtl/bit_ram_op_sched_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last winner, which loses the next tie.
module bit_ram_rr_arb (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  always_comb begin
    grant  = valid;
    last_d = last_q;
    if (valid == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    if (advance && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  // Reset as if requester 1 won last, so requester 0 takes the first tie.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/bit_ram_op_sched.sv
// Time-shares one bit RAM between two requesters: each op is IDLE (grant), RD (read A/B), WR (write D).
module bit_ram_op_sched
  import bit_ram_op_pkg::*;
#(
  parameter int AWIDTH = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  bit_ram_op_sched_if.slave req_if,
  output logic [AWIDTH-1:0] RAM_A_ADDR,
  input  logic              RAM_A_Q,
  output logic [AWIDTH-1:0] RAM_B_ADDR,
  input  logic              RAM_B_Q,
  output logic [AWIDTH-1:0] RAM_C_ADDR,
  output logic              RAM_C_DATA,
  output logic              RAM_C_WE_N
);

  state_e            state_q, state_d;
  logic              g_q, g_d;
  logic [2:0]        op_q, op_d;
  logic [AWIDTH-1:0] a_addr_q, a_addr_d;
  logic [AWIDTH-1:0] b_addr_q, b_addr_d;
  logic [AWIDTH-1:0] d_addr_q, d_addr_d;
  logic              res_q, res_d;
  logic              we_n_q, we_n_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              rsp_data_q, rsp_data_d;
  logic [1:0]        grant;
  logic [1:0]        ready;

  bit_ram_rr_arb u_arb (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .valid   (req_if.REQ_VALID),
    .advance (state_q == ST_IDLE),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    op_d        = op_q;
    a_addr_d    = a_addr_q;
    b_addr_d    = b_addr_q;
    d_addr_d    = d_addr_q;
    res_d       = res_q;
    we_n_d      = 1'b1;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    ready       = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          ready    = grant;
          g_d      = grant[1];
          op_d     = grant[1] ? req_if.REQ_OP[5:3] : req_if.REQ_OP[2:0];
          a_addr_d = grant[1] ? req_if.REQ_ADDR_A[2*AWIDTH-1:AWIDTH] : req_if.REQ_ADDR_A[AWIDTH-1:0];
          b_addr_d = grant[1] ? req_if.REQ_ADDR_B[2*AWIDTH-1:AWIDTH] : req_if.REQ_ADDR_B[AWIDTH-1:0];
          d_addr_d = grant[1] ? req_if.REQ_ADDR_D[2*AWIDTH-1:AWIDTH] : req_if.REQ_ADDR_D[AWIDTH-1:0];
          state_d  = ST_RD;
        end
      end
      // RAM read data settled after the falling edge; result and write strobe launch for WR.
      ST_RD: begin
        res_d   = bit_op_eval(op_q, RAM_A_Q, RAM_B_Q);
        we_n_d  = (op_q == OP_READ);
        state_d = ST_WR;
      end
      ST_WR: begin
        rsp_valid_d = g_q ? 2'b10 : 2'b01;
        rsp_data_d  = res_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      g_q         <= 1'b0;
      op_q        <= OP_READ;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      d_addr_q    <= '0;
      res_q       <= 1'b0;
      we_n_q      <= 1'b1;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      op_q        <= op_d;
      a_addr_q    <= a_addr_d;
      b_addr_q    <= b_addr_d;
      d_addr_q    <= d_addr_d;
      res_q       <= res_d;
      we_n_q      <= we_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_if.REQ_READY = ready;
  assign req_if.RSP_VALID = rsp_valid_q;
  assign req_if.RSP_DATA  = rsp_data_q;
  assign RAM_A_ADDR       = a_addr_q;
  assign RAM_B_ADDR       = b_addr_q;
  assign RAM_C_ADDR       = d_addr_q;
  assign RAM_C_DATA       = res_q;
  assign RAM_C_WE_N       = we_n_q;

endmodule

// File: tb/tb_bit_ram_op_sched.sv
// Directed bench for bit_ram_op_sched with a falling-edge 4x1 bit RAM model.
module tb_bit_ram_op_sched;
  import bit_ram_op_pkg::*;

  localparam int AW = 2;

  typedef struct {
    logic       req;
    logic [2:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] d;
    logic       pre_en;
    logic [3:0] pre;
    logic       exp;
    logic [3:0] post;
  } vec_t;

  logic          CLK;
  logic          RSTN;
  logic [AW-1:0] RAM_A_ADDR, RAM_B_ADDR, RAM_C_ADDR;
  logic          RAM_A_Q, RAM_B_Q, RAM_C_DATA, RAM_C_WE_N;

  logic [3:0] ram_q;
  logic       load_req;
  logic [3:0] load_val;

  int errors = 0;
  int checks = 0;

  bit_ram_op_sched_if #(.AWIDTH(AW)) bus ();

  bit_ram_op_sched #(.AWIDTH(AW)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .req_if     (bus.slave),
    .RAM_A_ADDR (RAM_A_ADDR),
    .RAM_A_Q    (RAM_A_Q),
    .RAM_B_ADDR (RAM_B_ADDR),
    .RAM_B_Q    (RAM_B_Q),
    .RAM_C_ADDR (RAM_C_ADDR),
    .RAM_C_DATA (RAM_C_DATA),
    .RAM_C_WE_N (RAM_C_WE_N)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bit RAM: reads and writes both happen on the falling edge.
  always @(negedge CLK) begin
    RAM_A_Q <= ram_q[RAM_A_ADDR];
    RAM_B_Q <= ram_q[RAM_B_ADDR];
    if (load_req) ram_q <= load_val;
    else if (!RAM_C_WE_N) ram_q[RAM_C_ADDR] <= RAM_C_DATA;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] val);
    load_val = val;
    load_req = 1'b1;
    @(negedge CLK);
    #1 load_req = 1'b0;
  endtask

  task automatic drive_req(input logic r, input logic [2:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] d);
    if (r) begin
      bus.REQ_OP[5:3] = op; bus.REQ_ADDR_A[3:2] = a; bus.REQ_ADDR_B[3:2] = b; bus.REQ_ADDR_D[3:2] = d;
    end else begin
      bus.REQ_OP[2:0] = op; bus.REQ_ADDR_A[1:0] = a; bus.REQ_ADDR_B[1:0] = b; bus.REQ_ADDR_D[1:0] = d;
    end
    bus.REQ_VALID = r ? 2'b10 : 2'b01;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic [1:0] oh;
    logic       got;
    oh  = v.req ? 2'b10 : 2'b01;
    got = 1'b0;
    if (v.pre_en) preload(v.pre);
    @(posedge CLK); #1;
    drive_req(v.req, v.op, v.a, v.b, v.d);
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (bus.REQ_READY != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, ".ready"}, {30'd0, bus.REQ_READY}, {30'd0, oh});
    @(posedge CLK); #1;
    bus.REQ_VALID = 2'b00;
    if (!got) return;
    @(negedge CLK);
    chk({tag, ".rd_we_n"}, {31'd0, RAM_C_WE_N}, 32'd1);
    chk({tag, ".rd_rsp"}, {30'd0, bus.RSP_VALID}, 32'd0);
    @(negedge CLK);
    chk({tag, ".wr_we_n"}, {31'd0, RAM_C_WE_N}, {31'd0, v.op == OP_READ});
    if (v.op != OP_READ) chk({tag, ".wr_addr"}, {30'd0, RAM_C_ADDR}, {30'd0, v.d});
    chk({tag, ".wr_data"}, {31'd0, RAM_C_DATA}, {31'd0, v.exp});
    @(negedge CLK);
    chk({tag, ".rsp_valid"}, {30'd0, bus.RSP_VALID}, {30'd0, oh});
    chk({tag, ".rsp_data"}, {31'd0, bus.RSP_DATA}, {31'd0, v.exp});
    chk({tag, ".ram"}, {28'd0, ram_q}, {28'd0, v.post});
    chk({tag, ".we_n_idle"}, {31'd0, RAM_C_WE_N}, 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    logic [1:0] seen;
    logic       bad;
    int         ngr;
    int         gcyc[8];
    logic [1:0] gval[8];

    //           req   op      a     b     d     pre   pre_val exp   post
    vecs[0]  = '{1'b0, OP_SET, 2'd0, 2'd0, 2'd2, 1'b1, 4'b0000, 1'b1, 4'b0100};
    vecs[1]  = '{1'b0, OP_READ,2'd2, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b0100};
    vecs[2]  = '{1'b1, OP_XOR, 2'd0, 2'd1, 2'd3, 1'b1, 4'b0001, 1'b1, 4'b1001};
    vecs[3]  = '{1'b1, OP_READ,2'd3, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b1, 4'b1001};
    vecs[4]  = '{1'b0, OP_NOT, 2'd0, 2'd0, 2'd0, 1'b1, 4'b0001, 1'b0, 4'b0000};
    vecs[5]  = '{1'b0, OP_READ,2'd0, 2'd0, 2'd0, 1'b0, 4'b0000, 1'b0, 4'b0000};
    vecs[6]  = '{1'b1, OP_MOV, 2'd3, 2'd0, 2'd1, 1'b1, 4'b1000, 1'b1, 4'b1010};
    vecs[7]  = '{1'b0, OP_AND, 2'd0, 2'd1, 2'd2, 1'b1, 4'b0011, 1'b1, 4'b0111};
    vecs[8]  = '{1'b1, OP_AND, 2'd0, 2'd1, 2'd2, 1'b1, 4'b0101, 1'b0, 4'b0001};
    vecs[9]  = '{1'b0, OP_OR,  2'd2, 2'd3, 2'd0, 1'b1, 4'b1000, 1'b1, 4'b1001};
    vecs[10] = '{1'b1, OP_OR,  2'd0, 2'd1, 2'd3, 1'b1, 4'b1100, 1'b0, 4'b0100};
    vecs[11] = '{1'b0, OP_XOR, 2'd1, 2'd1, 2'd0, 1'b1, 4'b0011, 1'b0, 4'b0010};
    vecs[12] = '{1'b1, OP_CLR, 2'd0, 2'd0, 2'd1, 1'b1, 4'b1111, 1'b0, 4'b1101};
    vecs[13] = '{1'b0, OP_AND, 2'd3, 2'd3, 2'd3, 1'b1, 4'b1000, 1'b1, 4'b1000};
    vecs[14] = '{1'b1, OP_MOV, 2'd1, 2'd0, 2'd2, 1'b1, 4'b0010, 1'b1, 4'b0110};

    RSTN = 1'b0;
    bus.REQ_VALID = 2'b00; bus.REQ_OP = '0;
    bus.REQ_ADDR_A = '0; bus.REQ_ADDR_B = '0; bus.REQ_ADDR_D = '0;
    load_req = 1'b1; load_val = 4'b0000;

    repeat (3) @(negedge CLK);
    #1 load_req = 1'b0;
    chk("rst.ready", {30'd0, bus.REQ_READY}, 32'd0);
    chk("rst.rsp_valid", {30'd0, bus.RSP_VALID}, 32'd0);
    chk("rst.rsp_data", {31'd0, bus.RSP_DATA}, 32'd0);
    chk("rst.addrs", {26'd0, RAM_A_ADDR, RAM_B_ADDR, RAM_C_ADDR}, 32'd0);
    chk("rst.c_data", {31'd0, RAM_C_DATA}, 32'd0);
    chk("rst.we_n", {31'd0, RAM_C_WE_N}, 32'd1);

    @(posedge CLK); #1 RSTN = 1'b1;
    seen = 2'b00;
    repeat (4) begin
      @(negedge CLK);
      seen = seen | bus.REQ_READY | bus.RSP_VALID;
      if (RAM_C_WE_N !== 1'b1) seen = 2'b11;
    end
    chk("idle.quiet", {30'd0, seen}, 32'd0);

    for (int i = 0; i < 14; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Both requesters held valid from reset: strict alternation every 3 cycles.
    @(posedge CLK); #1 RSTN = 1'b0;
    bus.REQ_OP = {OP_READ, OP_READ};
    bus.REQ_VALID = 2'b11;
    @(posedge CLK); #1 RSTN = 1'b1;
    ngr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.REQ_READY != 2'b00 && ngr < 8) begin
        gcyc[ngr] = c;
        gval[ngr] = bus.REQ_READY;
        ngr++;
      end
    end
    @(posedge CLK); #1 bus.REQ_VALID = 2'b00;
    repeat (4) @(negedge CLK);
    chk("rr.count", ngr, 32'd4);
    for (int k = 0; k < 4 && k < ngr; k++) begin
      chk($sformatf("rr.grant%0d", k), {30'd0, gval[k]}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk($sformatf("rr.cycle%0d", k), gcyc[k], 3 * k);
    end

    // Reset asserted in the middle of the WR cycle.
    preload(4'b0000);
    @(posedge CLK); #1 drive_req(1'b0, OP_SET, 2'd0, 2'd0, 2'd1);
    bad = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge CLK);
      if (bus.REQ_READY != 2'b00) begin
        bad = 1'b0;
        break;
      end
    end
    chk("mid.ready_seen", {31'd0, bad}, 32'd0);
    @(posedge CLK); #1 bus.REQ_VALID = 2'b00;
    @(negedge CLK);
    @(negedge CLK);
    chk("mid.wr_we_n", {31'd0, RAM_C_WE_N}, 32'd0);
    #1 RSTN = 1'b0;
    #1 chk("mid.we_n_drop", {31'd0, RAM_C_WE_N}, 32'd1);
    seen = 2'b00;
    repeat (3) begin
      @(negedge CLK);
      seen = seen | bus.RSP_VALID;
    end
    @(posedge CLK); #1 RSTN = 1'b1;
    @(negedge CLK);
    seen = seen | bus.RSP_VALID;
    chk("mid.no_rsp", {30'd0, seen}, 32'd0);
    run_vec("after_rst", vecs[14]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
